trace_monitor: RTL and testbench

TRACE_MONITOR -- requirements
Module: trace_monitor

---
 rtl/trace_monitor_if.sv | 25 ++
 rtl/trace_monitor.sv | 152 +++++++++++++++
 tb/tb_trace_monitor.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_monitor_if.sv
// Trace stream interface between the trace monitor (master) and its consumer (slave).
// Signals:
//   tr_valid  head entry available (master -> slave)
//   tr_ready  consumer accepts the head entry (slave -> master)
//   tr_pc, tr_inst, tr_rd, tr_wdata  head entry fields (master -> slave)
interface trace_monitor_if #(
    parameter int XLEN = 32
);
    logic            tr_valid;
    logic            tr_ready;
    logic [XLEN-1:0] tr_pc;
    logic [31:0]     tr_inst;
    logic [4:0]      tr_rd;
    logic [XLEN-1:0] tr_wdata;

    modport master (
        output tr_valid, tr_pc, tr_inst, tr_rd, tr_wdata,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_pc, tr_inst, tr_rd, tr_wdata,
        output tr_ready
    );
endinterface

// File: rtl/trace_monitor.sv
// Retirement trace monitor: captures retiring instructions into a first-word
// fall-through FIFO, counts run cycles / retirements / dropped captures and
// halts a run on a zero instruction, a retirement at HALT_PC, or a timeout.
// Ports:
//   clk, rstn          clock; asynchronous active-high reset
//   start              pulse that (re)starts a run, clearing counters and FIFO
//   trace_mode         0 off, 1 all retired, 2 RegWrite-only, 3 off
//   wb_*               write-back retirement bus
//   tr                 trace stream (master side)
//   running, halted    registered state decodes
//   halt_reason        0 none, 1 HALT_PC, 2 timeout, 3 zero instruction
//   cycle_cnt, retire_cnt, drop_cnt, overflow  run statistics
//
// state  | meaning
// IDLE   | after reset, waiting for the first start
// RUN    | counting, capturing and checking halt conditions
// HALT   | counters frozen, FIFO still drains, waiting for start
module trace_monitor #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 16,
    parameter int              TIMEOUT = 1000,
    parameter logic [XLEN-1:0] HALT_PC = 32'h0000_0400,
    parameter int              CW      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       trace_mode,
    input  logic             wb_valid,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic [31:0]      wb_inst,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_wdata,
    trace_monitor_if.master  tr,
    output logic             running,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [CW-1:0]    cycle_cnt,
    output logic [CW-1:0]    retire_cnt,
    output logic [CW-1:0]    drop_cnt,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * XLEN + 37;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t         state, state_nxt;
    logic [1:0]     halt_code;
    logic           active, cap, push, pop, drop, inc_cyc;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty;
    logic [EW-1:0]  mem [DEPTH];

    // State register; running/halted are loaded from the next state so they
    // come straight from flops.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state   <= S_IDLE;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == S_RUN);
            halted  <= (state_nxt == S_HALT);
        end
    end

    // Next-state logic; start always wins over a halt in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (start) state_nxt = S_RUN;
                     else if (halt_code != 2'd0) state_nxt = S_HALT;
            S_HALT:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode. The start cycle itself is spent restarting, so it
    // neither counts nor captures.
    always_comb begin
        halt_code = 2'd0;
        if (state == S_RUN) begin
            if (wb_valid && wb_inst == 32'd0)     halt_code = 2'd3;
            else if (wb_valid && wb_pc == HALT_PC) halt_code = 2'd1;
            else if (cycle_cnt == TO_LAST)         halt_code = 2'd2;
        end
        active  = (state == S_RUN) && !start;
        cap     = active && wb_valid &&
                  (trace_mode == 2'd1 || (trace_mode == 2'd2 && wb_regwrite));
        pop     = tr.tr_valid && tr.tr_ready;
        push    = cap && (!full || pop);
        drop    = cap && full && !pop;
        // The halting cycle is not counted, so a timeout leaves cycle_cnt at TIMEOUT-1.
        inc_cyc = active && (halt_code == 2'd0);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            halt_reason <= 2'd0;
        end else if (start) begin
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            halt_reason <= 2'd0;
        end else if (active) begin
            if (inc_cyc && cycle_cnt != '1)   cycle_cnt  <= cycle_cnt + 1'b1;
            if (wb_valid && retire_cnt != '1) retire_cnt <= retire_cnt + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
            if (halt_code != 2'd0) halt_reason <= halt_code;
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {wb_pc, wb_inst,
                                    (wb_regwrite ? wb_rd : 5'd0),
                                    (wb_regwrite ? wb_wdata : {XLEN{1'b0}})};
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign tr.tr_valid = !empty;
    assign {tr.tr_pc, tr.tr_inst, tr.tr_rd, tr.tr_wdata} = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_trace_monitor.sv
// Scoreboard testbench for trace_monitor: directed scenarios plus random traffic,
// checked against a rule-level reference model of the run/capture behaviour.
module tb_trace_monitor;
    localparam int          XLEN    = 32;
    localparam int          DEPTH   = 16;
    localparam int          TIMEOUT = 1000;
    localparam int          CW      = 16;
    localparam logic [31:0] HALT_PC = 32'h0000_0400;
    localparam int          SAT     = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } entry_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    trace_mode = 2'd0;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_pc = '0;
    logic [31:0]   wb_inst = '0;
    logic          wb_regwrite = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [31:0]   wb_wdata = '0;
    logic          running, halted, overflow;
    logic [1:0]    halt_reason;
    logic [CW-1:0] cycle_cnt, retire_cnt, drop_cnt;

    trace_monitor_if #(.XLEN(XLEN)) tr_bus ();

    trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_PC(HALT_PC), .CW(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .trace_mode(trace_mode),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .tr(tr_bus),
        .running(running), .halted(halted), .halt_reason(halt_reason),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    entry_t exp_q[$];

    // Reference model state: 0 idle, 1 run, 2 halt
    int m_state = 0;
    int m_cyc = 0, m_ret = 0, m_drop = 0, m_reason = 0;
    bit m_ovf = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_ret = 0; m_drop = 0; m_reason = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic check_status();
        check("running", running, m_state == 1);
        check("halted", halted, m_state == 2);
        check("halt_reason", halt_reason, m_reason);
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("retire_cnt", retire_cnt, m_ret);
        check("drop_cnt", drop_cnt, m_drop);
        check("overflow", overflow, m_ovf);
    endtask

    // Drives one cycle of inputs, advances the model, and checks status after the edge.
    // A restart is issued with tr_ready low so no handshake coincides with the flush.
    task automatic tick(input bit st, input logic [1:0] mode, input bit v,
                        input logic [31:0] pc, input logic [31:0] inst, input bit rw,
                        input logic [4:0] rd, input logic [31:0] wd, input bit rdy);
        bit     rdy_eff;
        bit     pop;
        int     code;
        entry_t e;
        rdy_eff = st ? 1'b0 : rdy;
        start = st; trace_mode = mode; wb_valid = v; wb_pc = pc; wb_inst = inst;
        wb_regwrite = rw; wb_rd = rd; wb_wdata = wd; tr_bus.tr_ready = rdy_eff;
        pop = rdy_eff && (exp_q.size() > 0);
        if (st) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1) begin
            code = 0;
            if (v && inst == 32'd0)    code = 3;
            else if (v && pc == HALT_PC) code = 2 - 1;
            else if (m_cyc == TIMEOUT - 1) code = 2;
            if (v && (mode == 2'd1 || (mode == 2'd2 && rw))) begin
                if (exp_q.size() < DEPTH || pop) begin
                    e.pc = pc; e.inst = inst;
                    e.rd = rw ? rd : 5'd0;
                    e.wdata = rw ? wd : 32'd0;
                    exp_q.push_back(e);
                end else begin
                    m_drop = sat_inc(m_drop);
                    m_ovf = 1;
                end
            end
            if (v) m_ret = sat_inc(m_ret);
            if (code != 0) begin
                m_state = 2;
                m_reason = code;
            end else begin
                m_cyc = sat_inc(m_cyc);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check_status();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 2'd1, 0, 32'h100, 32'h13, 0, 5'd0, 32'd0, rdy);
    endtask

    task automatic retire(input logic [1:0] mode, input logic [31:0] pc, input bit rw,
                          input bit rdy);
        tick(0, mode, 1, pc, 32'h0000_0013 | (pc << 7), rw, 5'(pc[6:2] | 5'd1),
             pc ^ 32'hA5A5_0000, rdy);
    endtask

    // Monitor: whenever the DUT hands over an entry, compare it with the oldest expected one.
    always @(negedge clk) begin
        entry_t got;
        entry_t want;
        if (!rstn && tr_bus.tr_valid && tr_bus.tr_ready) begin
            got = {tr_bus.tr_pc, tr_bus.tr_inst, tr_bus.tr_rd, tr_bus.tr_wdata};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: got pc=%0h with nothing expected at %0t",
                         got.pc, $time);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    bad++;
                    $display("FAIL entry: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h at %0t",
                             got.pc, got.inst, got.rd, got.wdata,
                             want.pc, want.inst, want.rd, want.wdata, $time);
                end
            end
        end
    end

    initial begin
        int frozen;
        tr_bus.tr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tr_valid", tr_bus.tr_valid, 0);
        check_status();
        rstn = 1'b0;

        // In-order capture with fall-through on the cycle after capture
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        retire(2'd1, 32'h0, 1, 0);
        check("fwft_valid", tr_bus.tr_valid, 1);
        check("fwft_pc", tr_bus.tr_pc, 0);
        retire(2'd1, 32'h4, 0, 1);
        retire(2'd1, 32'h8, 1, 1);
        idle(4, 1);
        check("s1_retire_cnt", retire_cnt, 3);
        check("s1_drained", tr_bus.tr_valid, 0);

        // RegWrite-only mode
        tick(1, 2'd2, 0, 0, 0, 0, 0, 0, 0);
        retire(2'd2, 32'h10, 1, 1);
        retire(2'd2, 32'h14, 0, 1);
        retire(2'd2, 32'h18, 0, 1);
        retire(2'd2, 32'h1C, 1, 1);
        idle(3, 1);
        check("s2_retire_cnt", retire_cnt, 4);

        // Overflow: 18 captures with no pops
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) retire(2'd1, 32'h1000 + 4 * i, 1, 0);
        check("s3_drop_cnt", drop_cnt, 2);
        check("s3_overflow", overflow, 1);
        idle(DEPTH + 2, 1);
        // 17th capture coincides with a pop: no drop
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) retire(2'd1, 32'h2000 + 4 * i, 1, 0);
        retire(2'd1, 32'h2040, 1, 1);
        check("s3b_drop_cnt", drop_cnt, 0);
        check("s3b_overflow", overflow, 0);
        idle(DEPTH + 2, 1);

        // HALT_PC retirement
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        retire(2'd1, 32'h3F8, 1, 1);
        retire(2'd1, HALT_PC, 1, 1);
        check("s4_halted", halted, 1);
        check("s4_reason", halt_reason, 1);
        frozen = int'(cycle_cnt);
        for (int i = 0; i < 4; i++) retire(2'd1, 32'h500 + 4 * i, 1, 1);
        check("s4_cycle_frozen", cycle_cnt, frozen);
        idle(3, 1);

        // Timeout, then zero instruction at HALT_PC
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        idle(TIMEOUT, 1);
        check("s5_reason", halt_reason, 2);
        check("s5_cycle_cnt", cycle_cnt, TIMEOUT - 1);
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 2'd1, 1, HALT_PC, 32'd0, 0, 5'd0, 32'd0, 1);
        check("s5_zero_reason", halt_reason, 3);
        idle(3, 1);

        // Reset mid-run with five entries queued
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) retire(2'd1, 32'h600 + 4 * i, 1, 0);
        #2;
        rstn = 1'b1;
        #1;
        model_reset();
        check("rst_async_valid", tr_bus.tr_valid, 0);
        check_status();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        tick(0, 2'd1, 1, 32'h700, 32'h13, 1, 5'd3, 32'h9, 1);
        check("post_rst_valid", tr_bus.tr_valid, 0);
        tick(1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        retire(2'd1, 32'h800, 1, 1);
        idle(3, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            logic [31:0] pc;
            logic [31:0] inst;
            st = (m_state != 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
            pc = ($urandom_range(0, 63) == 0) ? HALT_PC : ($urandom & 32'hFFFF_FFFC);
            inst = ($urandom_range(0, 127) == 0) ? 32'd0 : ($urandom | 32'd1);
            tick(st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pc, inst,
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 ($urandom_range(0, 2) != 0));
        end
        idle(DEPTH + 4, 1);
        check("leftover_entries", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
